// File: rtl/wb_poll_pkg.sv
// Shared definitions for the button/LED Wishbone poller: FSM encoding,
// bus constants and small helpers.
package wb_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_EVAL,
    ST_WR
  } state_t;

  localparam logic [3:0]  SEL_ALL      = 4'hF;
  localparam logic [31:0] DEF_BTN_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_LED_ADDR = 32'h3000_0004;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_button_led_poller_if.sv
// Classic Wishbone initiator-side bundle shared by the poller and its slave.
interface wb_button_led_poller_if;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wbm_single_xfer.sv
// One-shot Wishbone single transfer: registers the request on i_start, holds
// it until ack or until TIMEOUT cycles pass without one.
module wbm_single_xfer
  import wb_poll_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int RDW     = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  i_start,
  input  logic                  i_we,
  input  logic [31:0]           i_adr,
  input  logic [31:0]           i_dat,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [RDW-1:0]        o_rdata,
  wb_button_led_poller_if.master bus
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  logic          r_cyc;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [WW-1:0] r_wait;
  logic          w_ack;
  logic          w_expire;

  assign w_ack    = r_cyc & bus.wbm_ack_i;
  assign w_expire = r_cyc & ~bus.wbm_ack_i & (r_wait == LAST_WAIT);

  // Request fields are cleared whenever the bus is released so nothing
  // stale is left on the address/data lines between accesses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_sel  <= 4'h0;
      r_adr  <= 32'h0;
      r_dat  <= 32'h0;
      r_wait <= '0;
    end else if (w_ack || w_expire) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_sel  <= 4'h0;
      r_adr  <= 32'h0;
      r_dat  <= 32'h0;
      r_wait <= '0;
    end else if (r_cyc) begin
      r_wait <= r_wait + 1'b1;
    end else if (i_start) begin
      r_cyc  <= 1'b1;
      r_we   <= i_we;
      r_sel  <= SEL_ALL;
      r_adr  <= i_adr;
      r_dat  <= i_dat;
      r_wait <= '0;
    end
  end

  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_cyc;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_sel;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;

  assign o_done    = w_ack;
  assign o_timeout = w_expire;
  assign o_rdata   = bus.wbm_dat_i[RDW-1:0];

endmodule

// File: rtl/wb_button_led_poller.sv
// Hardware replacement for the button/LED firmware loop: polls the button
// register, tracks presses and mirrors the state onto the LED register.
module wb_button_led_poller
  import wb_poll_pkg::*;
#(
  parameter logic [31:0]     BTN_ADDR    = DEF_BTN_ADDR,
  parameter logic [31:0]     LED_ADDR    = DEF_LED_ADDR,
  parameter int              NBTN        = 1,
  parameter int              NLED        = 4,
  parameter int              POLL_CYCLES = 1000,
  parameter int              TIMEOUT     = 255,
  parameter logic [NLED-1:0] LED_ON      = 4'hD,
  parameter logic [NLED-1:0] LED_OFF     = 4'h0
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   enable_i,
  wb_button_led_poller_if.master bus,
  output logic [NBTN-1:0]        btn_state_o,
  output logic [7:0]             press_cnt_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_poll;
  logic [NBTN-1:0] r_sample;
  logic [NBTN-1:0] r_btn;
  logic [7:0]      r_press;
  logic            r_err;
  logic            r_first;
  logic            r_pend;

  logic            w_start;
  logic            w_we;
  logic [31:0]     w_adr;
  logic [31:0]     w_dat;
  logic            w_done;
  logic            w_timeout;
  logic [NBTN-1:0] w_rdata;
  logic            w_changed;
  logic [31:0]     w_pattern;

  assign w_changed = (r_sample != r_btn);
  // After EVAL the held state always equals the fresh sample.
  assign w_pattern = {{(32-NLED){1'b0}}, (r_sample != '0) ? LED_ON : LED_OFF};

  wbm_single_xfer #(
    .TIMEOUT (TIMEOUT),
    .RDW     (NBTN)
  ) u_xfer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .i_start   (w_start),
    .i_we      (w_we),
    .i_adr     (w_adr),
    .i_dat     (w_dat),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_rdata   (w_rdata),
    .bus       (bus)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_we    = 1'b0;
    w_adr   = BTN_ADDR;
    w_dat   = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && (r_poll == '0)) begin
          w_next  = ST_RD;
          w_start = 1'b1;
        end
      end
      ST_RD: begin
        if (w_done)         w_next = ST_EVAL;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_EVAL: begin
        if (r_first || w_changed || r_pend) begin
          w_next  = ST_WR;
          w_start = 1'b1;
          w_we    = 1'b1;
          w_adr   = LED_ADDR;
          w_dat   = w_pattern;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WR: begin
        if (w_done || w_timeout) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Poll timer only runs while idle and enabled; any access or a disable
  // rearms it so each poll gap is a full POLL_CYCLES of enabled idle time.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_poll   <= POLL_LOAD;
      r_sample <= '0;
      r_btn    <= '0;
      r_press  <= 8'h0;
      r_err    <= 1'b0;
      r_first  <= 1'b1;
      r_pend   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && enable_i) begin
        if (r_poll != '0) r_poll <= r_poll - 1'b1;
      end else begin
        r_poll <= POLL_LOAD;
      end
      if (w_timeout) r_err <= 1'b1;
      if (r_state == ST_RD && w_done) r_sample <= w_rdata;
      if (r_state == ST_EVAL) begin
        r_first <= 1'b0;
        if (w_changed) begin
          r_btn <= r_sample;
          if (r_btn == '0) r_press <= sat_inc8(r_press);
        end
      end
      if (r_state == ST_WR) begin
        if (w_done)         r_pend <= 1'b0;
        else if (w_timeout) r_pend <= 1'b1;
      end
    end
  end

  assign btn_state_o = r_btn;
  assign press_cnt_o = r_press;
  assign err_o       = r_err;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_button_led_poller.sv
// Bench for wb_button_led_poller: protocol-level reference model checked
// every cycle, directed scenarios with literal expectations, then random polls.
module tb_wb_button_led_poller;

  localparam int          P        = 16;
  localparam int          TO       = 255;
  localparam logic [31:0] BTN_ADR  = 32'h3000_0000;
  localparam logic [31:0] LED_ADR  = 32'h3000_0004;
  localparam logic [31:0] PAT_ON   = 32'h0000_000D;
  localparam logic [31:0] PAT_OFF  = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [0:0] btnState;
  logic [7:0] pressCnt;
  logic       errFlag;
  logic       busy;

  wb_button_led_poller_if bus();

  wb_button_led_poller #(
    .POLL_CYCLES (P),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .enable_i    (enable),
    .bus         (bus),
    .btn_state_o (btnState),
    .press_cnt_o (pressCnt),
    .err_o       (errFlag),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // Slave behaviour knobs
  logic btnIn = 1'b1;
  int   latency = 0;
  bit   noAckWr = 0;
  bit   noAckAll = 0;
  bit   stray = 0;
  int   slaveCnt = 0;

  // Bus observation log
  int            rdCount = 0;
  int            wrCount = 0;
  int            doneCount = 0;
  int            firstRdCycle = 0;
  int            curLen = 0;
  int            lastLen = 0;
  logic          prevCyc = 1'b0;
  logic [31:0]   wrLog[$];

  // Reference model, expressed as protocol phases
  typedef enum {M_IDLE, M_ACC, M_EVAL} mphase_t;
  mphase_t     mPhase = M_IDLE;
  bit          modelValid = 0;
  int          mNeed, mWaited, mPress;
  bit          mAccWr, mErr, mFirst, mPend, mBtn, mSample, doWr;
  logic [31:0] mAccAdr, mAccDat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // which: 0 = RD starts, 1 = WR starts, 2 = completed accesses
  task automatic waitCount(input int which, input int target, input string name);
    int v;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      v = (which == 0) ? rdCount : (which == 1) ? wrCount : doneCount;
      if (v >= target) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_%s: got timeout expected count %0d", name, target);
  endtask

  task automatic applyStimulus(input logic b, input int lat, input bit nw, input bit na, input bit s);
    btnIn    = b;
    latency  = lat;
    noAckWr  = nw;
    noAckAll = na;
    stray    = s;
  endtask

  // Model advances on the same edge the DUT samples, using pre-edge inputs.
  always @(posedge clk) begin
    if (rst) begin
      mPhase = M_IDLE; mNeed = P; mBtn = 0; mPress = 0; mErr = 0;
      mFirst = 1; mPend = 0; cycleNo = 1; modelValid = 1;
    end else begin
      cycleNo++;
      case (mPhase)
        M_IDLE: begin
          if (enable) begin
            mNeed--;
            if (mNeed == 0) begin
              mPhase = M_ACC; mAccWr = 0; mAccAdr = BTN_ADR; mAccDat = 0; mWaited = 0;
            end
          end else begin
            mNeed = P;
          end
        end
        M_ACC: begin
          if (bus.wbm_ack_i) begin
            if (!mAccWr) begin
              mSample = bus.wbm_dat_i[0];
              mPhase  = M_EVAL;
            end else begin
              mPend = 0; mPhase = M_IDLE; mNeed = P;
            end
          end else begin
            mWaited++;
            if (mWaited == TO) begin
              mErr = 1;
              if (mAccWr) mPend = 1;
              mPhase = M_IDLE; mNeed = P;
            end
          end
        end
        M_EVAL: begin
          doWr = mFirst || (mSample != mBtn) || mPend;
          if (!mBtn && mSample) mPress = (mPress < 255) ? mPress + 1 : 255;
          mBtn = mSample;
          mFirst = 0;
          if (doWr) begin
            mPhase = M_ACC; mAccWr = 1; mAccAdr = LED_ADR;
            mAccDat = mSample ? PAT_ON : PAT_OFF; mWaited = 0;
          end else begin
            mPhase = M_IDLE; mNeed = P;
          end
        end
        default: mPhase = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare against the model plus the bus transaction log.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cyc", bus.wbm_cyc_o, mPhase == M_ACC);
      checkOutput("stb", bus.wbm_stb_o, mPhase == M_ACC);
      if (mPhase == M_ACC) begin
        checkOutput("we",  bus.wbm_we_o, mAccWr);
        checkOutput("sel", bus.wbm_sel_o, 4'hF);
        checkOutput("adr", bus.wbm_adr_o, mAccAdr);
        if (mAccWr) checkOutput("dat", bus.wbm_dat_o, mAccDat);
      end
      checkOutput("btn_state", btnState, mBtn);
      checkOutput("press_cnt", pressCnt, mPress);
      checkOutput("err", errFlag, mErr);
      checkOutput("busy", busy, mPhase != M_IDLE);
    end
    if (bus.wbm_cyc_o === 1'b1 && prevCyc !== 1'b1) begin
      curLen = 1;
      if (bus.wbm_we_o) begin
        wrCount++;
        wrLog.push_back(bus.wbm_dat_o);
      end else begin
        rdCount++;
        if (firstRdCycle == 0) firstRdCycle = cycleNo;
      end
    end else if (bus.wbm_cyc_o === 1'b1) begin
      curLen++;
    end else if (prevCyc === 1'b1) begin
      lastLen = curLen;
      doneCount++;
    end
    prevCyc = bus.wbm_cyc_o;
  end

  // Slave: acks after 'latency' wait cycles, may withhold acks or emit stray ones.
  always @(negedge clk) begin
    bus.wbm_dat_i = {$urandom_range(0, 32'h7FFF_FFFF), btnIn};
    if (bus.wbm_cyc_o === 1'b1 && bus.wbm_stb_o === 1'b1) begin
      bus.wbm_ack_i = (!noAckAll && !(noAckWr && bus.wbm_we_o) && slaveCnt == latency);
      slaveCnt++;
    end else begin
      slaveCnt = 0;
      bus.wbm_ack_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin
    int r, w, d;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    rst = 1'b1;
    enable = 1'b0;
    applyStimulus(1'b1, 0, 0, 0, 0);
    step(3);
    checkOutput("reset_cyc", bus.wbm_cyc_o, 1'b0);
    checkOutput("reset_press", pressCnt, 8'd0);
    checkOutput("reset_err", errFlag, 1'b0);
    checkOutput("reset_btn", btnState, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;
    enable = 1'b1;

    // Buttons high from reset, single-cycle ack
    waitCount(1, 1, "first_wr");
    checkOutput("first_rd_cycle", firstRdCycle, P + 1);
    checkOutput("first_wr_data", wrLog[0], PAT_ON);
    checkOutput("first_press", pressCnt, 8'd1);

    // Held buttons: three more polls, no extra write
    r = rdCount; w = wrCount;
    waitCount(0, r + 3, "held_polls");
    step(4);
    checkOutput("held_wr_count", wrCount, w);
    checkOutput("held_press", pressCnt, 8'd1);

    // Release then press again
    applyStimulus(1'b0, 0, 0, 0, 0);
    waitCount(1, w + 1, "release_wr");
    applyStimulus(1'b1, 0, 0, 0, 0);
    waitCount(1, w + 2, "repress_wr");
    checkOutput("release_data", wrLog[w], PAT_OFF);
    checkOutput("repress_data", wrLog[w + 1], PAT_ON);
    checkOutput("repress_press", pressCnt, 8'd2);

    // Write that is never acknowledged, then recovery rewrite
    d = doneCount;
    waitCount(2, d + 1, "repress_done");
    applyStimulus(1'b0, 0, 0, 0, 0);
    w = wrCount;
    waitCount(1, w + 1, "off_wr");
    d = doneCount;
    waitCount(2, d + 1, "off_done");
    applyStimulus(1'b1, 0, 1, 0, 0);
    waitCount(1, w + 2, "stuck_wr");
    d = doneCount;
    waitCount(2, d + 1, "stuck_done");
    checkOutput("timeout_len", lastLen, 255);
    checkOutput("timeout_err", errFlag, 1'b1);
    applyStimulus(1'b1, 0, 0, 0, 0);
    waitCount(1, w + 3, "retry_wr");
    checkOutput("retry_data", wrLog[w + 2], PAT_ON);
    checkOutput("retry_press", pressCnt, 8'd3);

    // Slow slave with stray acks while idle
    applyStimulus(1'b1, 5, 0, 0, 1);
    r = rdCount;
    waitCount(0, r + 1, "slow_rd");
    d = doneCount;
    waitCount(2, d + 1, "slow_done");
    checkOutput("slow_len", lastLen, 6);

    // Reset while strobe is high
    applyStimulus(1'b1, 30, 0, 0, 0);
    r = rdCount;
    waitCount(0, r + 1, "pre_reset_rd");
    step(2);
    rst = 1'b1;
    firstRdCycle = 0;
    step(1);
    checkOutput("rst_cyc", bus.wbm_cyc_o, 1'b0);
    checkOutput("rst_stb", bus.wbm_stb_o, 1'b0);
    checkOutput("rst_press", pressCnt, 8'd0);
    checkOutput("rst_err", errFlag, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 0, 0, 0, 0);
    w = wrCount;
    waitCount(1, w + 1, "restart_wr");
    checkOutput("restart_rd_cycle", firstRdCycle, P + 1);
    checkOutput("restart_press", pressCnt, 8'd1);

    // Random polls; the per-cycle compare does the checking
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 4),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        step($urandom_range(1, 20));
        enable = 1'b1;
      end
      r = rdCount;
      waitCount(0, r + 1, "rand_rd");
      step($urandom_range(1, 10));
    end
    applyStimulus(1'b0, 0, 0, 0, 0);
    r = rdCount;
    waitCount(0, r + 2, "final_rd");
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
